// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one word read per instruction over a
// req/gnt + rvalid bus and presents the fetched word and its pc to the
// core under a valid/ready handshake. The core supplies every next pc.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    // instruction memory bus
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    // core side
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    input  logic [31:0] next_pc,
    // sticky error flags
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    // Last count value before the timeout fires; reaching it with no
    // response this cycle means the wait has lasted TIMEOUT cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t           state;
    logic [31:0]      fetch_pc;
    logic [CNT_W-1:0] wait_cnt;

    // Fetch FSM: state, fetch address, wait counter and every output register.
    // NOTE: outputs are assigned on the transition into the state that shows
    // them, so they are registered yet line up with the state register; all
    // assignments here are non-blocking so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            fetch_pc     <= RESET_PC;
            wait_cnt     <= '0;
            mem_req      <= 1'b0;
            mem_addr     <= RESET_PC;
            inst_valid   <= 1'b0;
            instruction  <= 32'h0;
            pc           <= 32'h0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state    <= S_REQ;
                    mem_req  <= 1'b1;
                    mem_addr <= fetch_pc;
                end

                // Address is held while the request waits for a grant.
                S_REQ: begin
                    if (mem_gnt) begin
                        state    <= S_WAIT;
                        mem_req  <= 1'b0;
                        wait_cnt <= '0;
                    end
                end

                S_WAIT: begin
                    if (mem_rvalid) begin
                        state       <= S_HOLD;
                        instruction <= mem_rdata;
                        pc          <= fetch_pc;
                        inst_valid  <= 1'b1;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= S_ERR;
                        wait_cnt    <= CNT_MAX;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // instruction/pc stay frozen until the core takes them.
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        if (next_pc[1:0] != 2'b00) begin
                            state        <= S_ERR;
                            misalign_err <= 1'b1;
                        end else begin
                            state    <= S_REQ;
                            fetch_pc <= next_pc;
                            mem_req  <= 1'b1;
                            mem_addr <= next_pc;
                        end
                    end
                end

                // Terminal: only reset leaves this state.
                S_ERR: begin
                    mem_req    <= 1'b0;
                    inst_valid <= 1'b0;
                end

                default: begin
                    state      <= S_ERR;
                    mem_req    <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: drives the memory and core sides by hand
// one cycle at a time and compares against hand-computed values.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        misalign_err;
    logic        timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .instruction (instruction),
        .pc          (pc),
        .next_pc     (next_pc),
        .misalign_err(misalign_err),
        .timeout_err (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // advance one clock; outputs are stable 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".mem_req"},      32'(mem_req),      32'd0);
        check({tag, ".mem_addr"},     mem_addr,          RST_PC);
        check({tag, ".inst_valid"},   32'(inst_valid),   32'd0);
        check({tag, ".instruction"},  instruction,       32'd0);
        check({tag, ".pc"},           pc,                32'd0);
        check({tag, ".misalign_err"}, 32'(misalign_err), 32'd0);
        check({tag, ".timeout_err"},  32'(timeout_err),  32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        inst_ready = 1'b0;
        next_pc    = 32'h0;
        #1;
        tick();
        tick();
        check_reset_state("rst0");

        // 1: zero-wait memory, first fetch from RESET_PC
        rst     = 1'b0;
        mem_gnt = 1'b1;
        tick();                                   // cycle 1: REQ
        check("t1.req",  32'(mem_req), 32'd1);
        check("t1.addr", mem_addr, 32'h8000_0000);
        check("t1.iv_req", 32'(inst_valid), 32'd0);
        tick();                                   // cycle 2: WAIT
        check("t1.req_drop", 32'(mem_req), 32'd0);
        check("t1.iv_wait", 32'(inst_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0297;
        tick();                                   // cycle 3: HOLD
        mem_rvalid = 1'b0;
        mem_gnt    = 1'b0;
        check("t1.iv",    32'(inst_valid), 32'd1);
        check("t1.pc",    pc, 32'h8000_0000);
        check("t1.instr", instruction, 32'h0000_0297);

        // 2: core stalls 5 cycles, then takes it with next_pc=+4
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t2.iv%0d", i),    32'(inst_valid), 32'd1);
            check($sformatf("t2.pc%0d", i),    pc, 32'h8000_0000);
            check($sformatf("t2.instr%0d", i), instruction, 32'h0000_0297);
            check($sformatf("t2.req%0d", i),   32'(mem_req), 32'd0);
        end
        inst_ready = 1'b1;
        next_pc    = 32'h8000_0004;
        tick();
        inst_ready = 1'b0;
        check("t2.req",  32'(mem_req), 32'd1);
        check("t2.addr", mem_addr, 32'h8000_0004);
        check("t2.iv_off", 32'(inst_valid), 32'd0);

        // 3: grant withheld 4 cycles, response 3 cycles after grant
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3.req%0d", i),  32'(mem_req), 32'd1);
            check($sformatf("t3.addr%0d", i), mem_addr, 32'h8000_0004);
        end
        mem_gnt = 1'b1;
        tick();                                   // WAIT, first cycle
        mem_gnt = 1'b0;
        check("t3.req_drop", 32'(mem_req), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("t3.iv_wait%0d", i), 32'(inst_valid), 32'd0);
            check($sformatf("t3.terr%0d", i),    32'(timeout_err), 32'd0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0041_0113;
        tick();
        check("t3.iv",    32'(inst_valid), 32'd1);
        check("t3.pc",    pc, 32'h8000_0004);
        check("t3.instr", instruction, 32'h0041_0113);
        mem_rdata = 32'hDEAD_BEEF;                // stray rvalid during HOLD
        tick();
        mem_rvalid = 1'b0;
        check("t3.single", instruction, 32'h0041_0113);
        check("t3.pc_hold", pc, 32'h8000_0004);

        // top-of-space next_pc is legal, no wrap problems
        inst_ready = 1'b1;
        next_pc    = 32'hFFFF_FFFC;
        tick();
        inst_ready = 1'b0;
        check("top.req",  32'(mem_req), 32'd1);
        check("top.addr", mem_addr, 32'hFFFF_FFFC);
        check("top.merr", 32'(misalign_err), 32'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_0013;
        tick();
        mem_rvalid = 1'b0;
        check("top.iv", 32'(inst_valid), 32'd1);
        check("top.pc", pc, 32'hFFFF_FFFC);

        // 4: misaligned next_pc traps until reset
        inst_ready = 1'b1;
        next_pc    = 32'h8000_0006;
        tick();
        check("t4.merr", 32'(misalign_err), 32'd1);
        check("t4.iv",   32'(inst_valid), 32'd0);
        check("t4.req",  32'(mem_req), 32'd0);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4.merr_h%0d", i), 32'(misalign_err), 32'd1);
            check($sformatf("t4.iv_h%0d", i),   32'(inst_valid), 32'd0);
            check($sformatf("t4.req_h%0d", i),  32'(mem_req), 32'd0);
        end
        mem_rvalid = 1'b0;
        inst_ready = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_state("t4.rst");

        // 5: TIMEOUT=4 with no response after grant
        rst     = 1'b0;
        mem_gnt = 1'b1;
        tick();                                   // REQ
        check("t5.req", 32'(mem_req), 32'd1);
        tick();                                   // WAIT entered
        mem_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5.terr_pre%0d", i), 32'(timeout_err), 32'd0);
        end
        tick();
        check("t5.terr",  32'(timeout_err), 32'd1);
        check("t5.merr",  32'(misalign_err), 32'd0);
        check("t5.iv",    32'(inst_valid), 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        tick();
        mem_rvalid = 1'b0;
        check("t5.late_iv",    32'(inst_valid), 32'd0);
        check("t5.late_instr", instruction, 32'd0);
        check("t5.terr_hold",  32'(timeout_err), 32'd1);
        check("t5.req_off",    32'(mem_req), 32'd0);
        rst = 1'b1;
        tick();
        check_reset_state("t5.rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
